// File: rtl/hp_mul_arbiter.sv
// Round-robin arbiter sharing one FP16 multiplier core between two requesters.
// Optional per-requester completion counters are enabled by defining HPMUL_ARB_STATS_EN.

module hp_mul_core (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_product,
  output logic [1:0]  o_exc
);
  // Subnormal operands are treated as zero; results below the normal range flush to zero.
  logic              w_sign;
  logic              w_a_special, w_b_special, w_a_nan, w_b_nan, w_a_zero, w_b_zero;
  logic [21:0]       w_sig_prod;
  logic signed [7:0] w_exp_sum, w_exp_norm, w_exp_fin;
  logic [9:0]        w_mant;
  logic              w_guard, w_sticky, w_round_up;
  logic [10:0]       w_mant_rnd;

  assign w_sign      = i_a[15] ^ i_b[15];
  assign w_a_special = &i_a[14:10];
  assign w_b_special = &i_b[14:10];
  assign w_a_nan     = w_a_special & (|i_a[9:0]);
  assign w_b_nan     = w_b_special & (|i_b[9:0]);
  assign w_a_zero    = ~|i_a[14:10];
  assign w_b_zero    = ~|i_b[14:10];
  assign w_sig_prod  = {11'd0, 1'b1, i_a[9:0]} * {11'd0, 1'b1, i_b[9:0]};
  assign w_exp_sum   = $signed({3'b000, i_a[14:10]}) + $signed({3'b000, i_b[14:10]}) - 8'sd15;

  always_comb begin
    w_mant     = w_sig_prod[19:10];
    w_guard    = w_sig_prod[9];
    w_sticky   = |w_sig_prod[8:0];
    w_exp_norm = w_exp_sum;
    if (w_sig_prod[21]) begin
      w_mant     = w_sig_prod[20:11];
      w_guard    = w_sig_prod[10];
      w_sticky   = |w_sig_prod[9:0];
      w_exp_norm = w_exp_sum + 8'sd1;
    end
    // Round to nearest, ties to even
    w_round_up = w_guard & (w_sticky | w_mant[0]);
    w_mant_rnd = {1'b0, w_mant} + {10'd0, w_round_up};
    w_exp_fin  = w_mant_rnd[10] ? (w_exp_norm + 8'sd1) : w_exp_norm;

    o_product = {w_sign, 15'd0};
    o_exc     = 2'b00;
    if (w_a_special || w_b_special) begin
      o_exc = 2'b11;
      if (w_a_nan || w_b_nan || (w_a_special && w_b_zero) || (w_b_special && w_a_zero))
        o_product = 16'h7E00;
      else
        o_product = {w_sign, 5'h1F, 10'd0};
    end else if (w_a_zero || w_b_zero) begin
      o_product = {w_sign, 15'd0};
    end else if (w_exp_fin >= 8'sd31) begin
      o_exc     = 2'b01;
      o_product = {w_sign, 5'h1F, 10'd0};
    end else if (w_exp_fin <= 8'sd0) begin
      o_exc     = 2'b10;
      o_product = {w_sign, 15'd0};
    end else begin
      o_product = {w_sign, w_exp_fin[4:0], w_mant_rnd[9:0]};
    end
  end
endmodule

// state | meaning
// IDLE  | waiting for a request; grant offered on o_req_ready
// EXEC  | latched operands held on the core for MUL_LAT cycles
// RESP  | result registered, waiting for i_resp_ready
module hp_mul_arbiter #(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [15:0]      i_req_a0,
  input  logic [15:0]      i_req_b0,
  input  logic [15:0]      i_req_a1,
  input  logic [15:0]      i_req_b1,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic             o_resp_id,
  output logic [15:0]      o_resp_product,
  output logic [1:0]       o_resp_exc,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_op_cnt0,
  output logic [CNT_W-1:0] o_op_cnt1
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [3:0] LP_CNT_INIT = 4'(MUL_LAT - 1);

  logic [1:0]  r_state;
  logic        r_rr_ptr;
  logic [15:0] r_op_a, r_op_b;
  logic        r_id;
  logic [3:0]  r_cnt;
  logic        r_resp_valid, r_resp_id;
  logic [15:0] r_resp_product;
  logic [1:0]  r_resp_exc;

  logic [1:0]  w_grant;
  logic        w_grant_id;
  logic        w_accept;
  logic [15:0] w_core_product;
  logic [1:0]  w_core_exc;

  always_comb begin
    w_grant = 2'b00;
    case (i_req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_rr_ptr ? 2'b10 : 2'b01;
      default: w_grant = 2'b00;
    endcase
  end

  assign w_grant_id  = w_grant[1];
  assign o_req_ready = ((r_state == ST_IDLE) && !i_rst) ? w_grant : 2'b00;
  assign w_accept    = |(i_req_valid & o_req_ready);

  // Core sees only the latched operands, so it can be timed as a multi-cycle path
  hp_mul_core u_core (
    .i_a       (r_op_a),
    .i_b       (r_op_b),
    .o_product (w_core_product),
    .o_exc     (w_core_exc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_rr_ptr       <= 1'b0;
      r_op_a         <= 16'd0;
      r_op_b         <= 16'd0;
      r_id           <= 1'b0;
      r_cnt          <= 4'd0;
      r_resp_valid   <= 1'b0;
      r_resp_id      <= 1'b0;
      r_resp_product <= 16'd0;
      r_resp_exc     <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op_a   <= w_grant_id ? i_req_a1 : i_req_a0;
            r_op_b   <= w_grant_id ? i_req_b1 : i_req_b0;
            r_id     <= w_grant_id;
            r_cnt    <= LP_CNT_INIT;
            r_rr_ptr <= ~w_grant_id;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_resp_product <= w_core_product;
            r_resp_exc     <= w_core_exc;
            r_resp_id      <= r_id;
            r_resp_valid   <= 1'b1;
            r_state        <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_resp_valid   = r_resp_valid;
  assign o_resp_id      = r_resp_id;
  assign o_resp_product = r_resp_product;
  assign o_resp_exc     = r_resp_exc;
  assign o_busy         = (r_state != ST_IDLE);

`ifdef HPMUL_ARB_STATS_EN
  localparam logic [CNT_W-1:0] LP_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] r_op_cnt0, r_op_cnt1;

  // Saturating: a counter stuck at all-ones means "at least that many"
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op_cnt0 <= '0;
      r_op_cnt1 <= '0;
    end else if (r_resp_valid && i_resp_ready) begin
      if (!r_resp_id && !(&r_op_cnt0)) r_op_cnt0 <= r_op_cnt0 + LP_CNT_ONE;
      if (r_resp_id && !(&r_op_cnt1))  r_op_cnt1 <= r_op_cnt1 + LP_CNT_ONE;
    end
  end

  assign o_op_cnt0 = r_op_cnt0;
  assign o_op_cnt1 = r_op_cnt1;
`else
  assign o_op_cnt0 = '0;
  assign o_op_cnt1 = '0;
`endif
endmodule

// File: tb/tb_hp_mul_arbiter.sv
// Directed bench for hp_mul_arbiter: MUL_LAT=2/CNT_W=2 main instance plus a MUL_LAT=1 instance.
// Counter expectations follow HPMUL_ARB_STATS_EN.

module tb_hp_mul_arbiter;
  localparam int MUL_LAT = 2;
  localparam int CNT_W   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_ready;
  logic [15:0]      a0, b0, a1, b1;
  logic             resp_valid, resp_ready, resp_id;
  logic [15:0]      resp_product;
  logic [1:0]       resp_exc;
  logic             busy;
  logic [CNT_W-1:0] op_cnt0, op_cnt1;

  logic [1:0]       l1_req_valid, l1_req_ready;
  logic [15:0]      l1_a0, l1_b0;
  logic             l1_resp_valid, l1_resp_ready, l1_resp_id;
  logic [15:0]      l1_resp_product;
  logic [1:0]       l1_resp_exc;
  logic             l1_busy;
  logic [15:0]      l1_cnt0, l1_cnt1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hp_mul_arbiter #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a0(a0), .i_req_b0(b0), .i_req_a1(a1), .i_req_b1(b1),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_id(resp_id),
    .o_resp_product(resp_product), .o_resp_exc(resp_exc), .o_busy(busy),
    .o_op_cnt0(op_cnt0), .o_op_cnt1(op_cnt1)
  );

  hp_mul_arbiter #(.MUL_LAT(1), .CNT_W(16)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(l1_req_valid), .o_req_ready(l1_req_ready),
    .i_req_a0(l1_a0), .i_req_b0(l1_b0), .i_req_a1(16'h0000), .i_req_b1(16'h0000),
    .o_resp_valid(l1_resp_valid), .i_resp_ready(l1_resp_ready), .o_resp_id(l1_resp_id),
    .o_resp_product(l1_resp_product), .o_resp_exc(l1_resp_exc), .o_busy(l1_busy),
    .o_op_cnt0(l1_cnt0), .o_op_cnt1(l1_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    resp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One uncontended op from requester rq, starting from IDLE, resp_ready held high
  task automatic run_op(input bit rq, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ep, input logic [1:0] ee, input string tag);
    int n;
    logic [1:0] want_rdy;
    if (rq) begin a1 = a; b1 = b; want_rdy = 2'b10; end
    else    begin a0 = a; b0 = b; want_rdy = 2'b01; end
    req_valid = want_rdy;
    resp_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, {30'd0, req_ready}, {30'd0, want_rdy});
    tick();
    req_valid = 2'b00;
    a0 = 16'hFFFF; b0 = 16'hFFFF; a1 = 16'hFFFF; b1 = 16'hFFFF;
    n = 1;
    while (!resp_valid && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, MUL_LAT + 1);
    check({tag, "_id"}, {31'd0, resp_id}, {31'd0, rq});
    check({tag, "_prod"}, {16'd0, resp_product}, {16'd0, ep});
    check({tag, "_exc"}, {30'd0, resp_exc}, {30'd0, ee});
    tick();
    check({tag, "_vdrop"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, k;
    int exp_cnt0;
    logic [15:0] exp_prod;

    rst = 1'b1;
    req_valid = 2'b00; resp_ready = 1'b0;
    a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0;
    l1_req_valid = 2'b00; l1_resp_ready = 1'b1; l1_a0 = 16'h0; l1_b0 = 16'h0;
    tick();
    tick();

    // Reset values, including req_ready suppressed while rst is high
    req_valid = 2'b11;
    #1;
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_id", {31'd0, resp_id}, 32'd0);
    check("rst_resp_product", {16'd0, resp_product}, 32'd0);
    check("rst_resp_exc", {30'd0, resp_exc}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cnt0", {30'd0, op_cnt0}, 32'd0);
    check("rst_cnt1", {30'd0, op_cnt1}, 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;

    // Single op
    run_op(1'b0, 16'h3C00, 16'h4000, 16'h4000, 2'b00, "single");

    // MUL_LAT=1 instance: EXEC lasts one cycle
    l1_a0 = 16'h3E00; l1_b0 = 16'h3E00; l1_req_valid = 2'b01;
    #1;
    check("l1_rdy", {30'd0, l1_req_ready}, 32'd1);
    tick();
    l1_req_valid = 2'b00;
    check("l1_exec_busy", {31'd0, l1_busy}, 32'd1);
    check("l1_exec_valid", {31'd0, l1_resp_valid}, 32'd0);
    tick();
    check("l1_resp_valid", {31'd0, l1_resp_valid}, 32'd1);
    check("l1_resp_prod", {16'd0, l1_resp_product}, 32'h4080);
    tick();
    check("l1_resp_drop", {31'd0, l1_resp_valid}, 32'd0);

    // Contention: grants alternate, one op every MUL_LAT+2 cycles
    do_reset();
    a0 = 16'hC000; b0 = 16'h3C00; a1 = 16'h3C00; b1 = 16'h3C00;
    req_valid = 2'b11; resp_ready = 1'b1;
    #1;
    check("cont_first_rdy", {30'd0, req_ready}, 32'd1);
    t = 0; k = 0;
    while (k < 4 && t < 40) begin
      tick();
      t++;
      if (resp_valid) begin
        exp_prod = (k % 2 == 0) ? 16'hC000 : 16'h3C00;
        check("cont_time", t, 3 + 4 * k);
        check("cont_id", {31'd0, resp_id}, k % 2);
        check("cont_prod", {16'd0, resp_product}, {16'd0, exp_prod});
        k++;
      end
    end
    req_valid = 2'b00;
    check("cont_count", k, 4);
    tick();
    check("cont_idle", {31'd0, busy}, 32'd0);

    // Backpressure: outputs frozen, no new grant while RESP
    do_reset();
    a0 = 16'h3E00; b0 = 16'h3E00; a1 = 16'h4000; b1 = 16'h4000;
    req_valid = 2'b01; resp_ready = 1'b0;
    #1;
    tick();
    req_valid = 2'b11;
    a0 = 16'h0000;
    t = 0;
    while (!resp_valid && t < 12) begin
      tick();
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_prod", {16'd0, resp_product}, 32'h4080);
      check("bp_id", {31'd0, resp_id}, 32'd0);
      check("bp_rdy", {30'd0, req_ready}, 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_hs_valid", {31'd0, resp_valid}, 32'd1);
    tick();
    check("bp_after_valid", {31'd0, resp_valid}, 32'd0);
    check("bp_after_busy", {31'd0, busy}, 32'd0);
    check("bp_after_rdy", {30'd0, req_ready}, 32'd2);
    req_valid = 2'b00;
    tick();

    // Exceptions and arithmetic corners
    run_op(1'b1, 16'h7C00, 16'h3C00, 16'h7C00, 2'b11, "exc_inf");
    run_op(1'b1, 16'h7E00, 16'h3C00, 16'h7E00, 2'b11, "exc_nan");
    run_op(1'b0, 16'h7BFF, 16'h4000, 16'h7C00, 2'b01, "exc_ovf");
    run_op(1'b0, 16'h0400, 16'h3800, 16'h0000, 2'b10, "exc_unf");
    run_op(1'b1, 16'h0000, 16'h4000, 16'h0000, 2'b00, "zero");
    run_op(1'b0, 16'h3C01, 16'h3C01, 16'h3C02, 2'b00, "mant");

    // Reset mid-op aborts without a response
    do_reset();
    a0 = 16'h4000; b0 = 16'h4000;
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    check("abort_exec_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, resp_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    req_valid = 2'b11;
    #1;
    check("abort_rr_ptr", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    run_op(1'b1, 16'h4000, 16'h4000, 16'h4400, 2'b00, "after_rst");

    // Completion counters saturate at all-ones
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, 16'h3C00, 16'h3C00, 16'h3C00, 2'b00, "cnt_op");
`ifdef HPMUL_ARB_STATS_EN
      exp_cnt0 = (i + 1 > 3) ? 3 : i + 1;
`else
      exp_cnt0 = 0;
`endif
      check("cnt0", {30'd0, op_cnt0}, exp_cnt0);
    end
    check("cnt1", {30'd0, op_cnt1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
